sd_drive_arbiter: RTL

Shares one MiSTer SD block-access port (sd_lba/sd_rd/sd_wr/sd_ack plus the sector buffer strobe) between two wd1793 floppy controllers running in SD mode (drive A and drive B). It selects one requester per sector transfer with round-robin fairness, latches that drive's LBA and direction, and routes ack, buffer writes and buffer read data to the granted drive only. It sits between the two wd1793 instances and the HPS/SD interface in the MSX top level. sd_buff_addr and sd_buff_dout are wired to both drives outside this block.

---
 rtl/sd_drive_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sd_drive_arbiter.sv
// Round-robin arbiter sharing one SD block-access port between two wd1793 drives.
// One sector transfer per grant; ack, buffer strobes and buffer data follow the granted drive.
module sd_drive_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba_a,
  input  logic [31:0] req_lba_b,
  input  logic [7:0]  req_buff_din_a,
  input  logic [7:0]  req_buff_din_b,
  output logic [1:0]  req_ack,
  output logic [1:0]  req_buff_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        grant_id,
  output logic        busy,
  output logic        timeout
);

  localparam int unsigned LBA_W = 32;
  localparam int unsigned CNT_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               grant_q, grant_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;

  logic [1:0]         pending;
  logic               pick;
  logic               wdog_hit;

  assign pending  = req_rd | req_wr;
  // On a tie the drive opposite the last served one wins.
  assign pick     = (&pending) ? ~last_q : pending[1];
  assign wdog_hit = (TIMEOUT != 24'd0) && (cnt_q == (TIMEOUT - 24'd1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      lba_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      lba_q     <= lba_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    lba_d     = lba_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|pending) begin
          grant_d = pick;
          lba_d   = pick ? req_lba_b : req_lba_a;
          rd_d    = req_rd[pick];
          wr_d    = ~req_rd[pick];
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else if (!pending[grant_q]) begin
          // Drive withdrew before the host answered; it keeps its turn.
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else if (wdog_hit) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          timeout_d = 1'b1;
          last_d    = grant_q;
          state_d   = IDLE;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign sd_lba      = lba_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;

  // Host-side strobes reach only the granted drive, and only while a grant is live.
  assign req_ack     = {2{sd_ack & busy_q}} & {grant_q, ~grant_q};
  assign req_buff_wr = {2{sd_buff_wr & busy_q}} & {grant_q, ~grant_q};
  assign sd_buff_din = grant_q ? req_buff_din_b : req_buff_din_a;

endmodule
